// File: rtl/param_mod_counter.sv
// Programmable-modulo up/down counter with wrap, saturate and one-shot modes.
// Emits a one-cycle terminal-count pulse and a sticky done flag in one-shot.
module param_mod_counter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             done,
  output logic             running
);

  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);

  localparam logic [1:0] MODE_WRAP = 2'b00;
  localparam logic [1:0] MODE_SAT  = 2'b01;
  localparam logic [1:0] MODE_ONE  = 2'b10;

  typedef enum logic {RUN = 1'b0, DONE = 1'b1} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] q_q;
  logic             tc_q;
  logic             done_q;

  logic [WIDTH-1:0] q_inc;
  logic [WIDTH-1:0] q_dec;
  logic             term_now;
  logic             term_next;

  // Up-terminal uses >= so a count parked above max_val (load or lowered
  // max_val) is caught on the next step instead of running to 2^WIDTH.
  always_comb begin
    q_inc     = q_q + WIDTH'(1);
    q_dec     = q_q - WIDTH'(1);
    term_now  = up_dn ? (q_q >= max_val) : (q_q == '0);
    term_next = up_dn ? (q_inc >= max_val) : (q_dec == '0);
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      q_q     <= RST_V;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
      state_q <= RUN;
    end else if (load) begin
      q_q     <= load_val;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
      state_q <= RUN;
    end else begin
      tc_q <= 1'b0;
      if (en && state_q == RUN) begin
        if (!term_now) begin
          q_q  <= up_dn ? q_inc : q_dec;
          tc_q <= term_next;
        end else begin
          case (mode)
            MODE_SAT: ;
            MODE_ONE: begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end
            default: begin
              q_q  <= up_dn ? '0 : max_val;
              tc_q <= 1'b1;
            end
          endcase
        end
      end
    end
  end

  assign q       = q_q;
  assign tc      = tc_q;
  assign done    = done_q;
  assign running = (state_q == RUN);

endmodule

// File: tb/tb_param_mod_counter.sv
// Directed bench: driver pushes hand-computed expectations, monitor pops and
// compares one registered output snapshot per clock.
module tb_param_mod_counter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, en, up_dn, clear, load;
  logic [W-1:0] load_val, max_val;
  logic [1:0]   mode;
  logic [W-1:0] q;
  logic         tc, done, running;

  typedef struct packed {
    logic [W-1:0] q;
    logic         tc;
    logic         done;
    logic         run;
  } exp_t;

  typedef struct {
    exp_t  e;
    string name;
  } sb_t;

  sb_t sb[$];
  int  checks = 0;
  int  errors = 0;
  bit  stim_done = 1'b0;

  param_mod_counter #(.WIDTH(W), .RESET_VAL(0)) dut (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clear(clear),
    .load(load), .load_val(load_val), .max_val(max_val), .mode(mode),
    .q(q), .tc(tc), .done(done), .running(running)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; expectation is for the state after the
  // following rising edge.
  task automatic cyc(input string nm, input logic r, input logic e,
                     input logic u, input logic c, input logic l,
                     input logic [W-1:0] lv, input logic [W-1:0] mv,
                     input logic [1:0] md, input logic [W-1:0] eq,
                     input logic etc, input logic edn, input logic erun);
    sb_t s;
    @(negedge clk);
    rst = r; en = e; up_dn = u; clear = c; load = l;
    load_val = lv; max_val = mv; mode = md;
    s.e = '{q: eq, tc: etc, done: edn, run: erun};
    s.name = nm;
    sb.push_back(s);
  endtask

  // Monitor: every clock the DUT presents one registered snapshot.
  initial begin
    sb_t  s;
    exp_t act;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        s = sb.pop_front();
        act = '{q: q, tc: tc, done: done, run: running};
        checks++;
        if (act !== s.e) begin
          errors++;
          $display("FAIL %s: got q=%0d tc=%b done=%b run=%b, want q=%0d tc=%b done=%b run=%b",
                   s.name, act.q, act.tc, act.done, act.run,
                   s.e.q, s.e.tc, s.e.done, s.e.run);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; up_dn = 1'b1; clear = 1'b0; load = 1'b0;
    load_val = '0; max_val = '0; mode = 2'b00;

    // 1: reset, then wrap up-count 0..9,0,1
    cyc("reset0", 1,0,1,0,0, 0,9,2'b00, 0,0,0,1);
    cyc("reset1", 1,1,1,0,0, 0,9,2'b00, 0,0,0,1);
    for (int i = 1; i <= 9; i++)
      cyc("wrap_up", 0,1,1,0,0, 0,9,2'b00, W'(i), (i == 9), 0,1);
    cyc("wrap_up_0",  0,1,1,0,0, 0,9,2'b00, 0,1,0,1);
    cyc("wrap_up_1",  0,1,1,0,0, 0,9,2'b00, 1,0,0,1);

    // 2: down wrap from loaded 2, max 5
    cyc("dn_load",    0,0,0,0,1, 2,5,2'b00, 2,0,0,1);
    cyc("dn_1",       0,1,0,0,0, 0,5,2'b00, 1,0,0,1);
    cyc("dn_0",       0,1,0,0,0, 0,5,2'b00, 0,1,0,1);
    cyc("dn_wrap5",   0,1,0,0,0, 0,5,2'b00, 5,1,0,1);
    cyc("dn_4",       0,1,0,0,0, 0,5,2'b00, 4,0,0,1);

    // 3: saturate at 3, then leave saturation downward
    cyc("sat_clr",    0,0,1,1,0, 0,3,2'b01, 0,0,0,1);
    cyc("sat_1",      0,1,1,0,0, 0,3,2'b01, 1,0,0,1);
    cyc("sat_2",      0,1,1,0,0, 0,3,2'b01, 2,0,0,1);
    cyc("sat_3",      0,1,1,0,0, 0,3,2'b01, 3,1,0,1);
    cyc("sat_hold_a", 0,1,1,0,0, 0,3,2'b01, 3,0,0,1);
    cyc("sat_hold_b", 0,1,1,0,0, 0,3,2'b01, 3,0,0,1);
    cyc("sat_down",   0,1,0,0,0, 0,3,2'b01, 2,0,0,1);

    // 4: one-shot to 4, DONE holds, load restarts
    cyc("os_clr",     0,0,1,1,0, 0,4,2'b10, 0,0,0,1);
    for (int i = 1; i <= 4; i++)
      cyc("os_up", 0,1,1,0,0, 0,4,2'b10, W'(i), (i == 4), 0,1);
    cyc("os_done",    0,1,1,0,0, 0,4,2'b10, 4,0,1,0);
    for (int i = 0; i < 5; i++)
      cyc("os_hold", 0,1,(i % 2 == 0),0,0, 0,4,(i == 3) ? 2'b00 : 2'b10, 4,0,1,0);
    cyc("os_reload",  0,0,1,0,1, 1,4,2'b10, 1,0,0,1);

    // 5: priority
    cyc("pri_load_en",  0,1,1,0,1, 7,9,2'b00, 7,0,0,1);
    cyc("pri_clr_load", 0,1,1,1,1, 7,9,2'b00, 0,0,0,1);
    cyc("pri_ld5",      0,0,1,0,1, 5,6,2'b10, 5,0,0,1);
    cyc("pri_6",        0,1,1,0,0, 0,6,2'b10, 6,1,0,1);
    cyc("pri_done6",    0,1,1,0,0, 0,6,2'b10, 6,0,1,0);
    cyc("pri_rst",      1,1,1,0,0, 0,6,2'b10, 0,0,0,1);

    // 6: boundaries
    cyc("bnd_ld12",     0,0,1,0,1, 12,9,2'b00, 12,0,0,1);
    cyc("bnd_over",     0,1,1,0,0, 0,9,2'b00, 0,1,0,1);
    for (int i = 0; i < 3; i++)
      cyc("bnd_max0", 0,1,1,0,0, 0,0,2'b00, 0,1,0,1);
    cyc("bnd_ld5",      0,0,1,0,1, 5,9,2'b00, 5,0,0,1);
    for (int i = 0; i < 3; i++)
      cyc("bnd_en0", 0,0,(i == 1),0,0, 0,(i == 2) ? 4'd2 : 4'd9,2'b00, 5,0,0,1);
    cyc("bnd_low_max",  0,1,1,0,0, 0,2,2'b01, 5,0,0,1);
    stim_done = 1'b1;
  end

  // Drain scoreboard with a bounded wait, then summarise.
  initial begin
    wait (stim_done);
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
